vlsu_txn_tracker: RTL and testbench

- Per-channel outstanding-burst tracker between the address generator and the AXI cut in the vector load/store unit.
- Generalises the fixed load/store pair to NrChannels channels: channel 0 is load (OffsetLoad), channel 1 is store (OffsetStore), extra channels are for future ports.
- Caps in-flight bursts per channel at Depth and back-pressures the AX channel when full.
- Converts per-burst completions (R last or B) into per-instruction completion pulses with an accumulated error flag, which the current unit does not provide.

---
 rtl/vlsu_txn_tracker_pkg.sv | 21 ++
 rtl/vlsu_txn_chan.sv | 115 +++++++++++
 rtl/vlsu_txn_tracker.sv | 67 ++++++
 tb/tb_vlsu_txn_tracker.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vlsu_txn_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vlsu_txn_tracker_pkg
// Description : Shared constants and types for the VLSU transaction tracker.
//               Channel indices double as the load/store port offsets.
// Revision    : 1.0 - initial release
// ============================================================================
package vlsu_txn_tracker_pkg;

    // Channel index assignment: load first, store second, extras follow.
    localparam int unsigned OffsetLoad  = 0;
    localparam int unsigned OffsetStore = 1;

    // Per-burst tag stored in the tracking FIFO. Kept as a struct so further
    // fields (e.g. an instruction ID) can be appended without touching users.
    typedef struct packed {
        logic last_insn;
    } txn_tag_t;

endpackage
`default_nettype wire

// File: rtl/vlsu_txn_chan.sv
`default_nettype none
// ============================================================================
// Module      : vlsu_txn_chan
// Description : One tracker channel: Depth-entry FIFO of burst tags, an
//               occupancy counter and a per-instruction error accumulator.
// Ports       : clk_i/rst_ni            clock, async active-low reset
//               ax_valid_i/ax_ready_i   burst handshake inputs
//               ax_last_insn_i          tag of the pushed burst
//               ax_valid_o/ax_ready_o   handshake gated by the full flag
//               cpl_valid_i/cpl_err_i   qualified burst completion
//               insn_complete_o/err_o   registered per-instruction pulse
//               pending_o/full_o        occupancy status
//               proto_err_o             sticky completion-while-empty flag
// Revision    : 1.0 - initial release
// ============================================================================
module vlsu_txn_chan
    import vlsu_txn_tracker_pkg::*;
#(
    parameter int unsigned Depth    = 8,
    parameter int unsigned CntWidth = $clog2(Depth + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ax_valid_i,
    input  logic ax_last_insn_i,
    output logic ax_valid_o,
    input  logic ax_ready_i,
    output logic ax_ready_o,
    input  logic cpl_valid_i,
    input  logic cpl_err_i,
    output logic insn_complete_o,
    output logic insn_err_o,
    output logic pending_o,
    output logic full_o,
    output logic proto_err_o
);

    localparam int unsigned PtrWidth = $clog2(Depth);

    txn_tag_t              tag_mem [Depth];
    logic [PtrWidth-1:0]   wr_ptr;
    logic [PtrWidth-1:0]   rd_ptr;
    logic [CntWidth-1:0]   occ;
    logic [CntWidth-1:0]   occ_next;
    logic                  err_acc;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    txn_tag_t              head_tag;

    // Full is decoded from registered occupancy only, so a same-cycle
    // completion never opens the AX handshake combinationally.
    assign full     = (occ == CntWidth'(Depth));
    assign empty    = (occ == '0);
    assign push     = ax_valid_i & ax_ready_i & ~full;
    assign pop      = cpl_valid_i & ~empty;
    assign head_tag = tag_mem[rd_ptr];

    assign ax_valid_o = ax_valid_i & ~full;
    assign ax_ready_o = ax_ready_i & ~full;
    assign full_o     = full;

    always_comb begin
        occ_next = occ;
        if (push && !pop) begin
            occ_next = occ + CntWidth'(1);
        end else if (pop && !push) begin
            occ_next = occ - CntWidth'(1);
        end
    end

    // Tag storage needs no reset: entries are only read behind the pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_mem[wr_ptr] <= '{last_insn: ax_last_insn_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            occ             <= '0;
            err_acc         <= 1'b0;
            insn_complete_o <= 1'b0;
            insn_err_o      <= 1'b0;
            pending_o       <= 1'b0;
            proto_err_o     <= 1'b0;
        end else begin
            occ             <= occ_next;
            pending_o       <= (occ_next != '0);
            insn_complete_o <= 1'b0;
            insn_err_o      <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrWidth'(1);
                if (head_tag.last_insn) begin
                    insn_complete_o <= 1'b1;
                    insn_err_o      <= err_acc | cpl_err_i;
                    err_acc         <= 1'b0;
                end else begin
                    err_acc <= err_acc | cpl_err_i;
                end
            end
            if (cpl_valid_i && empty) begin
                proto_err_o <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vlsu_txn_tracker.sv
`default_nettype none
// ============================================================================
// Module      : vlsu_txn_tracker
// Description : Per-channel outstanding-burst tracker between the VLSU address
//               generator and the AXI cut. Caps in-flight bursts per channel
//               and turns burst completions into instruction completions.
// Ports       : all per-channel vectors are NrChannels wide; bit OffsetLoad is
//               the load channel and bit OffsetStore the store channel.
// Revision    : 1.0 - initial release
// ============================================================================
module vlsu_txn_tracker #(
    parameter int unsigned NrChannels    = 2,
    parameter int unsigned Depth         = 8,
    parameter int unsigned CntWidth      = $clog2(Depth + 1),
    parameter bit          CheckProtoErr = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NrChannels-1:0] ax_valid_i,
    input  logic [NrChannels-1:0] ax_last_insn_i,
    output logic [NrChannels-1:0] ax_valid_o,
    input  logic [NrChannels-1:0] ax_ready_i,
    output logic [NrChannels-1:0] ax_ready_o,
    input  logic [NrChannels-1:0] cpl_valid_i,
    input  logic [NrChannels-1:0] cpl_err_i,
    output logic [NrChannels-1:0] insn_complete_o,
    output logic [NrChannels-1:0] insn_err_o,
    output logic [NrChannels-1:0] pending_o,
    output logic [NrChannels-1:0] full_o,
    output logic [NrChannels-1:0] proto_err_o
);

    for (genvar c = 0; c < NrChannels; c++) begin : g_chan
        vlsu_txn_chan #(
            .Depth    (Depth),
            .CntWidth (CntWidth)
        ) u_chan (
            .clk_i           (clk_i),
            .rst_ni          (rst_ni),
            .ax_valid_i      (ax_valid_i[c]),
            .ax_last_insn_i  (ax_last_insn_i[c]),
            .ax_valid_o      (ax_valid_o[c]),
            .ax_ready_i      (ax_ready_i[c]),
            .ax_ready_o      (ax_ready_o[c]),
            .cpl_valid_i     (cpl_valid_i[c]),
            .cpl_err_i       (cpl_err_i[c]),
            .insn_complete_o (insn_complete_o[c]),
            .insn_err_o      (insn_err_o[c]),
            .pending_o       (pending_o[c]),
            .full_o          (full_o[c]),
            .proto_err_o     (proto_err_o[c])
        );
    end

`ifndef SYNTHESIS
    a_depth_pow2 : assert property (@(posedge clk_i)
        (Depth >= 2) && ((Depth & (Depth - 1)) == 0));

    // Enabled only for nominal traffic where completions never outrun pushes.
    if (CheckProtoErr) begin : g_proto_chk
        a_no_proto_err : assert property (@(posedge clk_i) disable iff (!rst_ni)
            proto_err_o == '0);
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vlsu_txn_tracker.sv
`timescale 1ns/1ps
module tb_vlsu_txn_tracker;

    localparam int NCH   = 2;
    localparam int DEPTH = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] av = '0, last = '0, ar = '0, cv = '0, ce = '0;
    logic [NCH-1:0] avo, aro, icpl, ierr, pend, full, perr;

    int checks = 0;
    int failures = 0;
    int dut_pulses = 0;
    int tag1_pushed = 0;

    vlsu_txn_tracker #(.NrChannels(NCH), .Depth(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ax_valid_i(av), .ax_last_insn_i(last), .ax_valid_o(avo),
        .ax_ready_i(ar), .ax_ready_o(aro),
        .cpl_valid_i(cv), .cpl_err_i(ce),
        .insn_complete_o(icpl), .insn_err_o(ierr),
        .pending_o(pend), .full_o(full), .proto_err_o(perr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: per-channel queue of tags ----------
    bit       mq [NCH][$];
    bit [NCH-1:0] m_cpl, m_err, m_proto, m_acc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) mq[c].delete();
            m_cpl = '0; m_err = '0; m_proto = '0; m_acc = '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                bit was_full, do_push;
                was_full = (mq[c].size() == DEPTH);
                do_push  = av[c] && ar[c] && !was_full;
                m_cpl[c] = 1'b0;
                m_err[c] = 1'b0;
                if (cv[c] && mq[c].size() > 0) begin
                    bit t;
                    t = mq[c].pop_front();
                    if (t) begin
                        m_cpl[c] = 1'b1;
                        m_err[c] = m_acc[c] | ce[c];
                        m_acc[c] = 1'b0;
                    end else begin
                        m_acc[c] = m_acc[c] | ce[c];
                    end
                end else if (cv[c]) begin
                    m_proto[c] = 1'b1;
                end
                if (do_push) begin
                    mq[c].push_back(last[c]);
                    if (last[c]) tag1_pushed++;
                end
            end
        end
    end

    // ---------------- every-cycle compare against the model -----------------
    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            bit mfull;
            mfull = (mq[c].size() == DEPTH);
            check($sformatf("ax_valid_o[%0d]", c), 32'(avo[c]), 32'(av[c] & ~mfull));
            check($sformatf("ax_ready_o[%0d]", c), 32'(aro[c]), 32'(ar[c] & ~mfull));
            check($sformatf("full_o[%0d]", c),     32'(full[c]), 32'(mfull));
            check($sformatf("pending_o[%0d]", c),  32'(pend[c]), 32'(mq[c].size() != 0));
            check($sformatf("insn_complete_o[%0d]", c), 32'(icpl[c]), 32'(m_cpl[c]));
            check($sformatf("insn_err_o[%0d]", c), 32'(ierr[c]), 32'(m_err[c]));
            check($sformatf("proto_err_o[%0d]", c), 32'(perr[c]), 32'(m_proto[c]));
            if (rst_n && icpl[c]) dut_pulses++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NCH-1:0] v, input logic [NCH-1:0] r,
                         input logic [NCH-1:0] l, input logic [NCH-1:0] c,
                         input logic [NCH-1:0] e);
        av = v; ar = r; last = l; cv = c; ce = e;
    endtask

    task automatic idle();
        drive('0, '0, '0, '0, '0);
    endtask

    initial begin
        // ---------------- reset ----------------
        idle();
        ar = 2'b11;
        #2;
        check("reset pending", 32'(pend), 0);
        check("reset full", 32'(full), 0);
        check("reset ax_ready_o follows input", 32'(aro), 32'h3);
        repeat (2) tick();
        rst_n = 1'b1;
        idle();
        tick();

        // ---------------- single instruction, 3 bursts on ch0 --------------
        drive(2'b01, 2'b01, 2'b00, 2'b00, 2'b00); tick();
        check("t1 pending after first push", 32'(pend[0]), 1);
        drive(2'b01, 2'b01, 2'b00, 2'b00, 2'b00); tick();
        drive(2'b01, 2'b01, 2'b01, 2'b00, 2'b00); tick();
        drive('0, '0, '0, 2'b01, '0); tick();
        tick();
        check("t1 no pulse after 2nd cpl", 32'(icpl[0]), 0);
        tick();
        check("t1 pulse after 3rd cpl", 32'(icpl[0]), 1);
        check("t1 insn_err", 32'(ierr[0]), 0);
        idle(); tick();
        check("t1 pulse one cycle only", 32'(icpl[0]), 0);
        check("t1 pending cleared", 32'(pend[0]), 0);

        // ---------------- fill to Depth ----------------
        for (int i = 0; i < DEPTH; i++) begin
            drive(2'b01, 2'b01, 2'b01, '0, '0); tick();
        end
        check("t2 full_o", 32'(full[0]), 1);
        check("t2 ax_ready_o blocked", 32'(aro[0]), 0);
        drive(2'b01, 2'b01, 2'b01, 2'b01, '0); #1;
        check("t2 no push in pop cycle", 32'(aro[0]), 0);
        tick();
        check("t2 full dropped after pop", 32'(full[0]), 0);
        check("t2 ready reopened", 32'(aro[0]), 1);
        drive(2'b01, 2'b01, 2'b01, '0, '0); tick();
        check("t2 9th push accepted", 32'(full[0]), 1);
        for (int i = 0; i < DEPTH; i++) begin
            drive('0, '0, '0, 2'b01, '0); tick();
            check("t2 back-to-back drain pulse", 32'(icpl[0]), 1);
        end
        idle(); tick();

        // ---------------- error accumulation ----------------
        drive(2'b01, 2'b01, 2'b00, '0, '0); tick();
        drive(2'b01, 2'b01, 2'b01, '0, '0); tick();
        drive(2'b01, 2'b01, 2'b01, '0, '0); tick();
        drive('0, '0, '0, 2'b01, 2'b01); tick();
        drive('0, '0, '0, 2'b01, 2'b00); tick();
        check("t3 pulse A", 32'(icpl[0]), 1);
        check("t3 err A", 32'(ierr[0]), 1);
        tick();
        check("t3 pulse B", 32'(icpl[0]), 1);
        check("t3 err B cleared", 32'(ierr[0]), 0);
        idle(); tick();

        // ---------------- simultaneous push/pop at occupancy 4 -------------
        for (int i = 0; i < 4; i++) begin
            drive(2'b01, 2'b01, (i == 3) ? 2'b01 : 2'b00, '0, '0); tick();
        end
        drive(2'b01, 2'b01, 2'b00, 2'b01, '0); tick();
        check("t4 model occupancy 4", 32'(mq[0].size()), 4);
        for (int i = 0; i < 3; i++) begin
            drive('0, '0, '0, 2'b01, '0); tick();
        end
        check("t4 one left after 3 pops", 32'(pend[0]), 1);
        drive('0, '0, '0, 2'b01, '0); tick();
        check("t4 empty after 4 pops", 32'(pend[0]), 0);
        idle(); tick();

        dut_pulses = 0;
        tag1_pushed = 0;
        for (int i = 0; i < 20; i++) begin
            logic [NCH-1:0] c;
            for (int k = 0; k < NCH; k++) c[k] = $urandom_range(0, 1) && (mq[k].size() > 0);
            drive(NCH'($urandom), NCH'($urandom), NCH'($urandom), c, NCH'($urandom));
            tick();
        end
        idle();
        for (int i = 0; i < 40 && (mq[0].size() > 0 || mq[1].size() > 0); i++) begin
            for (int k = 0; k < NCH; k++) cv[k] = (mq[k].size() > 0);
            tick();
        end
        idle(); tick(); tick();
        check("t4 drained within budget", 32'(mq[0].size() + mq[1].size()), 0);
        check("t4 pulses equal tag-1 pushes", 32'(dut_pulses), 32'(tag1_pushed));

        // ---------------- protocol error ----------------
        drive(2'b01, 2'b01, 2'b01, 2'b10, '0); tick();
        check("t5 proto_err ch1", 32'(perr[1]), 1);
        check("t5 proto_err ch0 clean", 32'(perr[0]), 0);
        check("t5 no pulse ch1", 32'(icpl[1]), 0);
        check("t5 ch0 push accepted", 32'(pend[0]), 1);
        idle(); tick(); tick();
        check("t5 proto_err sticky", 32'(perr[1]), 1);

        // ---------------- async reset mid-traffic ----------------
        drive(2'b11, 2'b11, 2'b01, 2'b01, '0); tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6 async reset pending", 32'(pend), 0);
        check("t6 async reset proto_err", 32'(perr), 0);
        check("t6 async reset pulse", 32'(icpl), 0);
        check("t6 async reset full", 32'(full), 0);
        check("t6 ax_ready follows input", 32'(aro), 32'h3);
        idle(); tick(); tick();
        rst_n = 1'b1;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got hang expected finish");
        $fatal(1, "timeout");
    end

endmodule
